// File: rtl/pipe_execute_stage.sv
// ============================================================================
// Module      : pipe_execute_stage
// Description : Y86 execute stage - ALU, condition codes, branch/cmov
//               condition, forwarding outputs and the E-to-M pipeline register.
// Revision    : 1.0 - initial clocked implementation
// ============================================================================
`default_nettype none

module pipe_execute_stage #(
  parameter int         WIDTH      = 64,
  parameter int         STACK_STEP = WIDTH / 8,
  parameter logic [3:0] REG_NONE   = 4'hF,
  parameter logic [2:0] CC_RESET   = 3'b100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       e_stat,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_ifun,
  input  logic [WIDTH-1:0] e_valC,
  input  logic [WIDTH-1:0] e_valA,
  input  logic [WIDTH-1:0] e_valB,
  input  logic [3:0]       e_dstE,
  input  logic [3:0]       e_dstM,
  input  logic             cc_suppress,
  input  logic             M_stall,
  input  logic             M_bubble,
  output logic [WIDTH-1:0] x_valE,
  output logic [3:0]       x_dstE,
  output logic             x_cnd,
  output logic [2:0]       cc,
  output logic [2:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM
);

  localparam logic [2:0] c_STAT_AOK = 3'd1;

  localparam logic [3:0] c_I_NOP    = 4'h1;
  localparam logic [3:0] c_I_RRMOVQ = 4'h2;
  localparam logic [3:0] c_I_IRMOVQ = 4'h3;
  localparam logic [3:0] c_I_RMMOVQ = 4'h4;
  localparam logic [3:0] c_I_MRMOVQ = 4'h5;
  localparam logic [3:0] c_I_OPQ    = 4'h6;
  localparam logic [3:0] c_I_JXX    = 4'h7;
  localparam logic [3:0] c_I_CALL   = 4'h8;
  localparam logic [3:0] c_I_RET    = 4'h9;
  localparam logic [3:0] c_I_PUSHQ  = 4'hA;
  localparam logic [3:0] c_I_POPQ   = 4'hB;

  localparam logic [3:0] c_ALU_ADD  = 4'h0;
  localparam logic [3:0] c_ALU_SUB  = 4'h1;
  localparam logic [3:0] c_ALU_AND  = 4'h2;
  localparam logic [3:0] c_ALU_XOR  = 4'h3;

  localparam logic [3:0] c_C_ALWAYS = 4'h0;
  localparam logic [3:0] c_C_LE     = 4'h1;
  localparam logic [3:0] c_C_L      = 4'h2;
  localparam logic [3:0] c_C_E      = 4'h3;
  localparam logic [3:0] c_C_NE     = 4'h4;
  localparam logic [3:0] c_C_GE     = 4'h5;
  localparam logic [3:0] c_C_G      = 4'h6;

  localparam logic [WIDTH-1:0] c_STEP = WIDTH'(STACK_STEP);

  // --------------------------------------------------------------------------
  // OPq arithmetic and flag generation
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] opq_res;
  logic             opq_valid;
  logic             flag_zf;
  logic             flag_sf;
  logic             flag_of;
  logic             sign_a;
  logic             sign_b;
  logic             sign_r;

  assign sign_a = e_valA[WIDTH-1];
  assign sign_b = e_valB[WIDTH-1];
  assign sign_r = opq_res[WIDTH-1];

  always_comb begin
    opq_res   = '0;
    opq_valid = 1'b1;
    case (e_ifun)
      c_ALU_ADD: opq_res = e_valB + e_valA;
      c_ALU_SUB: opq_res = e_valB - e_valA;
      c_ALU_AND: opq_res = e_valB & e_valA;
      c_ALU_XOR: opq_res = e_valB ^ e_valA;
      default: begin
        opq_res   = '0;
        opq_valid = 1'b0;
      end
    endcase
  end

  always_comb begin
    flag_zf = (opq_res == '0);
    flag_sf = sign_r;
    flag_of = 1'b0;
    case (e_ifun)
      c_ALU_ADD: flag_of = (sign_a == sign_b) && (sign_r != sign_a);
      c_ALU_SUB: flag_of = (sign_a != sign_b) && (sign_r != sign_b);
      default:   flag_of = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Result selection per instruction class
  // --------------------------------------------------------------------------
  always_comb begin
    x_valE = '0;
    case (e_icode)
      c_I_OPQ:                x_valE = opq_res;
      c_I_RRMOVQ:             x_valE = e_valA;
      c_I_IRMOVQ:             x_valE = e_valC;
      c_I_RMMOVQ, c_I_MRMOVQ: x_valE = e_valB + e_valC;
      c_I_CALL, c_I_PUSHQ:    x_valE = e_valB - c_STEP;
      c_I_RET, c_I_POPQ:      x_valE = e_valB + c_STEP;
      default:                x_valE = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Condition-code register
  // --------------------------------------------------------------------------
  logic [2:0] cc_q;
  logic [2:0] cc_d;
  logic       cc_load;

  assign cc_load = (e_icode == c_I_OPQ) && opq_valid &&
                   (e_stat == c_STAT_AOK) && !cc_suppress;

  always_comb begin
    cc_d = cc_q;
    if (cc_load) begin
      cc_d = {flag_zf, flag_sf, flag_of};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_q <= CC_RESET;
    end else begin
      cc_q <= cc_d;
    end
  end

  assign cc = cc_q;

  // --------------------------------------------------------------------------
  // Branch / cmov condition from the registered flags
  // --------------------------------------------------------------------------
  logic cc_zf;
  logic cc_sf;
  logic cc_of;
  logic cond_raw;

  assign cc_zf = cc_q[2];
  assign cc_sf = cc_q[1];
  assign cc_of = cc_q[0];

  always_comb begin
    cond_raw = 1'b0;
    case (e_ifun)
      c_C_ALWAYS: cond_raw = 1'b1;
      c_C_LE:     cond_raw = (cc_sf ^ cc_of) | cc_zf;
      c_C_L:      cond_raw = cc_sf ^ cc_of;
      c_C_E:      cond_raw = cc_zf;
      c_C_NE:     cond_raw = ~cc_zf;
      c_C_GE:     cond_raw = ~(cc_sf ^ cc_of);
      c_C_G:      cond_raw = ~(cc_sf ^ cc_of) & ~cc_zf;
      default:    cond_raw = 1'b0;
    endcase
  end

  always_comb begin
    x_cnd = 1'b0;
    if ((e_icode == c_I_RRMOVQ) || (e_icode == c_I_JXX)) begin
      x_cnd = cond_raw;
    end
  end

  // A failed cmov must not write its destination.
  assign x_dstE = ((e_icode == c_I_RRMOVQ) && !x_cnd) ? REG_NONE : e_dstE;

  // --------------------------------------------------------------------------
  // E-to-M pipeline register
  // --------------------------------------------------------------------------
  logic [2:0]       m_stat_q,  m_stat_d;
  logic [3:0]       m_icode_q, m_icode_d;
  logic             m_cnd_q,   m_cnd_d;
  logic [WIDTH-1:0] m_valE_q,  m_valE_d;
  logic [WIDTH-1:0] m_valA_q,  m_valA_d;
  logic [3:0]       m_dstE_q,  m_dstE_d;
  logic [3:0]       m_dstM_q,  m_dstM_d;

  always_comb begin
    m_stat_d  = m_stat_q;
    m_icode_d = m_icode_q;
    m_cnd_d   = m_cnd_q;
    m_valE_d  = m_valE_q;
    m_valA_d  = m_valA_q;
    m_dstE_d  = m_dstE_q;
    m_dstM_d  = m_dstM_q;
    if (M_bubble) begin
      m_stat_d  = c_STAT_AOK;
      m_icode_d = c_I_NOP;
      m_cnd_d   = 1'b0;
      m_valE_d  = '0;
      m_valA_d  = '0;
      m_dstE_d  = REG_NONE;
      m_dstM_d  = REG_NONE;
    end else if (!M_stall) begin
      m_stat_d  = e_stat;
      m_icode_d = e_icode;
      m_cnd_d   = x_cnd;
      m_valE_d  = x_valE;
      m_valA_d  = e_valA;
      m_dstE_d  = x_dstE;
      m_dstM_d  = e_dstM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_stat_q  <= c_STAT_AOK;
      m_icode_q <= c_I_NOP;
      m_cnd_q   <= 1'b0;
      m_valE_q  <= '0;
      m_valA_q  <= '0;
      m_dstE_q  <= REG_NONE;
      m_dstM_q  <= REG_NONE;
    end else begin
      m_stat_q  <= m_stat_d;
      m_icode_q <= m_icode_d;
      m_cnd_q   <= m_cnd_d;
      m_valE_q  <= m_valE_d;
      m_valA_q  <= m_valA_d;
      m_dstE_q  <= m_dstE_d;
      m_dstM_q  <= m_dstM_d;
    end
  end

  assign M_stat  = m_stat_q;
  assign M_icode = m_icode_q;
  assign M_cnd   = m_cnd_q;
  assign M_valE  = m_valE_q;
  assign M_valA  = m_valA_q;
  assign M_dstE  = m_dstE_q;
  assign M_dstM  = m_dstM_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_execute_stage.sv
// ============================================================================
// Module      : tb_pipe_execute_stage
// Description : Self-checking bench for pipe_execute_stage against an
//               arithmetic reference model, plus directed corner cases.
// Revision    : 1.0 - initial bench
// ============================================================================
`default_nettype none

module tb_pipe_execute_stage;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   e_stat;
  logic [3:0]   e_icode, e_ifun, e_dstE, e_dstM;
  logic [W-1:0] e_valC, e_valA, e_valB;
  logic         cc_suppress, M_stall, M_bubble;
  logic [W-1:0] x_valE;
  logic [3:0]   x_dstE;
  logic         x_cnd;
  logic [2:0]   cc;
  logic [2:0]   M_stat;
  logic [3:0]   M_icode, M_dstE, M_dstM;
  logic         M_cnd;
  logic [W-1:0] M_valE, M_valA;

  // 32-bit instance with an 8-byte stack step
  logic         t_rst;
  logic [3:0]   t_icode;
  logic [31:0]  t_valB;
  logic [31:0]  t_x_valE, t_M_valE, t_M_valA;
  logic [3:0]   t_x_dstE, t_M_icode, t_M_dstE, t_M_dstM;
  logic         t_x_cnd, t_M_cnd;
  logic [2:0]   t_cc, t_M_stat;

  always #5 clk = ~clk;

  pipe_execute_stage #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .e_stat(e_stat), .e_icode(e_icode), .e_ifun(e_ifun),
    .e_valC(e_valC), .e_valA(e_valA), .e_valB(e_valB), .e_dstE(e_dstE),
    .e_dstM(e_dstM), .cc_suppress(cc_suppress), .M_stall(M_stall),
    .M_bubble(M_bubble), .x_valE(x_valE), .x_dstE(x_dstE), .x_cnd(x_cnd),
    .cc(cc), .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  pipe_execute_stage #(.WIDTH(32), .STACK_STEP(8)) dut32 (
    .clk(clk), .rst(t_rst), .e_stat(3'd1), .e_icode(t_icode), .e_ifun(4'h0),
    .e_valC(32'h0), .e_valA(32'h0), .e_valB(t_valB), .e_dstE(4'h4),
    .e_dstM(4'hF), .cc_suppress(1'b0), .M_stall(1'b0), .M_bubble(1'b0),
    .x_valE(t_x_valE), .x_dstE(t_x_dstE), .x_cnd(t_x_cnd), .cc(t_cc),
    .M_stat(t_M_stat), .M_icode(t_M_icode), .M_cnd(t_M_cnd),
    .M_valE(t_M_valE), .M_valA(t_M_valA), .M_dstE(t_M_dstE), .M_dstM(t_M_dstM)
  );

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [2:0]   ecc;
  logic [2:0]   em_stat;
  logic [3:0]   em_icode, em_dstE, em_dstM;
  logic         em_cnd;
  logic [W-1:0] em_valE, em_valA;
  logic         last_xcnd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arithmetic model: overflow means the exact signed result does not fit in W bits.
  function automatic void model_alu(input logic [3:0] ic, input logic [3:0] fn,
                                    input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [W-1:0] c, output logic [W-1:0] ve,
                                    output logic [2:0] fl, output logic fv);
    logic signed [W+1:0] sa, sb, s;
    logic                ovf;
    sa  = $signed({{2{a[W-1]}}, a});
    sb  = $signed({{2{b[W-1]}}, b});
    s   = '0;
    ovf = 1'b0;
    ve  = '0;
    fl  = 3'b000;
    fv  = 1'b0;
    case (ic)
      4'h6: begin
        if (fn <= 4'd3) begin
          fv = 1'b1;
          if (fn == 4'd0) s = sb + sa;
          else if (fn == 4'd1) s = sb - sa;
          if (fn <= 4'd1) begin
            ve  = s[W-1:0];
            ovf = (s != $signed({{2{s[W-1]}}, s[W-1:0]}));
          end else if (fn == 4'd2) begin
            ve = a & b;
          end else begin
            ve = a ^ b;
          end
          fl = {ve == '0, ve[W-1], ovf};
        end
      end
      4'h2:       ve = a;
      4'h3:       ve = c;
      4'h4, 4'h5: ve = b + c;
      4'h8, 4'hA: ve = b - 64'd8;
      4'h9, 4'hB: ve = b + 64'd8;
      default:    ve = '0;
    endcase
  endfunction

  function automatic logic model_cnd(input logic [3:0] ic, input logic [3:0] fn,
                                     input logic [2:0] f);
    logic zf, lt;
    zf = f[2];
    lt = (f[1] != f[0]);
    if (ic != 4'h2 && ic != 4'h7) return 1'b0;
    case (fn)
      4'd0:    return 1'b1;
      4'd1:    return lt || zf;
      4'd2:    return lt;
      4'd3:    return zf;
      4'd4:    return !zf;
      4'd5:    return !lt;
      4'd6:    return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // One pipeline cycle: drive, check forwarding, clock, check M and cc.
  task automatic cyc(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                     input logic [W-1:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [3:0] de, input logic [3:0] dm,
                     input logic sup, input logic stl, input logic bub, input logic r);
    logic [W-1:0] ve;
    logic [2:0]   fl;
    logic         fv, cn;
    logic [3:0]   xd;
    e_stat = st; e_icode = ic; e_ifun = fn; e_valC = c; e_valA = a; e_valB = b;
    e_dstE = de; e_dstM = dm; cc_suppress = sup; M_stall = stl; M_bubble = bub; rst = r;
    #2;
    model_alu(ic, fn, a, b, c, ve, fl, fv);
    cn = model_cnd(ic, fn, ecc);
    xd = (ic == 4'h2 && !cn) ? 4'hF : de;
    chk("x_valE", x_valE, ve);
    chk("x_cnd", {63'd0, x_cnd}, {63'd0, cn});
    chk("x_dstE", {60'd0, x_dstE}, {60'd0, xd});
    last_xcnd = x_cnd;
    if (r) ecc = 3'b100;
    else if (fv && st == 3'd1 && !sup) ecc = fl;
    if (r || bub) begin
      em_stat = 3'd1; em_icode = 4'h1; em_cnd = 1'b0; em_valE = '0; em_valA = '0;
      em_dstE = 4'hF; em_dstM = 4'hF;
    end else if (!stl) begin
      em_stat = st; em_icode = ic; em_cnd = cn; em_valE = ve; em_valA = a;
      em_dstE = xd; em_dstM = dm;
    end
    @(posedge clk);
    #1;
    chk("cc", {61'd0, cc}, {61'd0, ecc});
    chk("M_stat", {61'd0, M_stat}, {61'd0, em_stat});
    chk("M_icode", {60'd0, M_icode}, {60'd0, em_icode});
    chk("M_cnd", {63'd0, M_cnd}, {63'd0, em_cnd});
    chk("M_valE", M_valE, em_valE);
    chk("M_valA", M_valA, em_valA);
    chk("M_dstE", {60'd0, M_dstE}, {60'd0, em_dstE});
    chk("M_dstM", {60'd0, M_dstM}, {60'd0, em_dstM});
  endtask

  // Shorthand for a plain AOK instruction with no hazard control
  task automatic run(input logic [3:0] ic, input logic [3:0] fn, input logic [W-1:0] c,
                     input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] de);
    cyc(3'd1, ic, fn, c, a, b, de, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 expected less");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ra, rb, rc;
    logic [3:0]   ric;
    rst = 1'b1; e_stat = 3'd1; e_icode = 4'h1; e_ifun = 4'h0; e_valC = '0; e_valA = '0;
    e_valB = '0; e_dstE = 4'hF; e_dstM = 4'hF; cc_suppress = 1'b0; M_stall = 1'b0;
    M_bubble = 1'b0; t_rst = 1'b1; t_icode = 4'h1; t_valB = '0;
    ecc = 3'b100; em_stat = 3'd1; em_icode = 4'h1; em_cnd = 1'b0; em_valE = '0;
    em_valA = '0; em_dstE = 4'hF; em_dstM = 4'hF; last_xcnd = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    cyc(3'd1, 4'h1, 4'h0, '0, '0, '0, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_cc", {61'd0, cc}, 64'h4);
    chk("rst_icode", {60'd0, M_icode}, 64'h1);
    chk("rst_stat", {61'd0, M_stat}, 64'h1);
    chk("rst_dstE", {60'd0, M_dstE}, 64'hF);
    chk("rst_dstM", {60'd0, M_dstM}, 64'hF);
    chk("rst_valE", M_valE, 64'h0);

    // addq overflow, then subq to zero
    run(4'h6, 4'h0, '0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 4'h2);
    chk("addq_valE", M_valE, 64'h8000_0000_0000_0000);
    chk("addq_cc", {61'd0, cc}, 64'h3);
    run(4'h6, 4'h1, '0, 64'd5, 64'd5, 4'h2);
    chk("subq_valE", M_valE, 64'h0);
    chk("subq_cc", {61'd0, cc}, 64'h4);

    // cmovle with cc=000 then cc=100
    run(4'h6, 4'h0, '0, 64'd1, 64'd1, 4'h2);
    chk("cc000", {61'd0, cc}, 64'h0);
    run(4'h2, 4'h1, '0, 64'h42, 64'h0, 4'h3);
    chk("cmov_n_xcnd", {63'd0, last_xcnd}, 64'h0);
    chk("cmov_n_dstE", {60'd0, M_dstE}, 64'hF);
    chk("cmov_n_valE", M_valE, 64'h42);
    chk("cmov_n_cnd", {63'd0, M_cnd}, 64'h0);
    run(4'h6, 4'h1, '0, 64'd5, 64'd5, 4'h2);
    run(4'h2, 4'h1, '0, 64'h42, 64'h0, 4'h3);
    chk("cmov_y_dstE", {60'd0, M_dstE}, 64'h3);
    chk("cmov_y_cnd", {63'd0, M_cnd}, 64'h1);

    // CC blocked by suppress and by non-AOK status
    run(4'h6, 4'h0, '0, 64'd1, 64'd1, 4'h2);
    cyc(3'd1, 4'h6, 4'h1, '0, 64'd5, 64'd5, 4'h2, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sup_cc", {61'd0, cc}, 64'h0);
    cyc(3'd3, 4'h6, 4'h1, '0, 64'd5, 64'd5, 4'h2, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("adr_cc", {61'd0, cc}, 64'h0);
    chk("adr_stat", {61'd0, M_stat}, 64'h3);

    // Stack pointer arithmetic
    run(4'hA, 4'h0, '0, 64'h0, 64'h100, 4'h4);
    chk("push_valE", M_valE, 64'hF8);
    run(4'hB, 4'h0, '0, 64'h0, 64'h100, 4'h4);
    chk("pop_valE", M_valE, 64'h108);

    // Invalid icode
    cyc(3'd4, 4'hE, 4'h0, 64'h55, 64'h66, 64'h77, 4'h5, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("inv_valE", M_valE, 64'h0);
    chk("inv_stat", {61'd0, M_stat}, 64'h4);

    // Stall holds for two cycles, stall+bubble loads a bubble
    run(4'h3, 4'h0, 64'h1234, 64'h0, 64'h0, 4'h7);
    cyc(3'd1, 4'h6, 4'h0, '0, 64'd9, 64'd3, 4'h1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(3'd1, 4'h5, 4'h0, 64'd8, 64'd1, 64'd3, 4'h1, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("stall_valE", M_valE, 64'h1234);
    chk("stall_icode", {60'd0, M_icode}, 64'h3);
    cyc(3'd1, 4'h6, 4'h0, '0, 64'd9, 64'd3, 4'h1, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("bub_icode", {60'd0, M_icode}, 64'h1);
    chk("bub_dstE", {60'd0, M_dstE}, 64'hF);

    // jXX at a stall edge still drives x_cnd
    run(4'h6, 4'h1, '0, 64'd5, 64'd5, 4'h2);
    cyc(3'd1, 4'h7, 4'h3, 64'h400, '0, '0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("jxx_stall_xcnd", {63'd0, last_xcnd}, 64'h1);

    // Randomised traffic including mid-stream resets
    for (int i = 0; i < 600; i++) begin
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      rc  = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) ra = rb;
      if ($urandom_range(0, 3) == 0) ra = {1'b0, {(W-1){1'b1}}} - W'($urandom_range(0, 3));
      ric = ($urandom_range(0, 2) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 4)) : 3'd1,
          ric, 4'($urandom_range(0, 7)), rc, ra, rb,
          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0));
    end

    // 32-bit push wraps below zero
    t_rst = 1'b0; t_icode = 4'hA; t_valB = 32'h0;
    #2;
    chk("w32_x_valE", {32'd0, t_x_valE}, 64'hFFFF_FFF8);
    @(posedge clk);
    #1;
    chk("w32_M_valE", {32'd0, t_M_valE}, 64'hFFFF_FFF8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_execute_stage.md
Name: pipe_execute_stage

Overview:
- Parametrised execute stage for the 5-stage pipelined Y86 processor. Replaces the event-triggered, unclocked execute block.
- Computes the ALU result and branch/cmov condition from the decode-to-execute (E) register contents.
- Owns the condition-code register and the execute-to-memory (M) pipeline register, with stall and bubble control from the pipeline controller.
- Provides same-cycle combinational forwarding outputs to decode.

Parameters:
WIDTH, 64, datapath width in bits for valC, valA, valB and valE; must be a multiple of 8 and at least 16.
STACK_STEP, WIDTH/8, byte decrement/increment applied to %rsp by call, push, ret and pop.
REG_NONE, 4'hF, register ID meaning "no destination".
CC_RESET, 3'b100, reset value of {ZF,SF,OF}.

Ports:
clk  in  1  pipeline clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
e_stat  in  3  instruction status from E register (1=AOK, 2=HLT, 3=ADR, 4=INS)
e_icode  in  4  instruction code
e_ifun  in  4  function code
e_valC  in  WIDTH  constant word
e_valA  in  WIDTH  operand A (rA or forwarded value)
e_valB  in  WIDTH  operand B (rB or %rsp)
e_dstE  in  4  ALU destination register ID
e_dstM  in  4  memory destination register ID
cc_suppress  in  1  high when M-stage or W-stage status is not AOK; blocks the CC update
M_stall  in  1  hold the M register
M_bubble  in  1  load a bubble into the M register
x_valE  out  WIDTH  combinational ALU result (forwarding)
x_dstE  out  4  combinational effective dstE (forwarding)
x_cnd  out  1  combinational condition result
cc  out  3  registered {ZF,SF,OF}
M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM  out  3,4,1,WIDTH,WIDTH,4,4  M pipeline register

Behaviour:
ALU operand selection (operation is B op A, truncated to WIDTH, two's complement):
- icode 6 OPq: op = add/sub/and/xor for ifun 0/1/2/3; A=valA, B=valB. ifun above 3 gives valE=0.
- icode 2 rrmovq/cmovXX: valE = 0 + valA.
- icode 3 irmovq: valE = 0 + valC.
- icode 4/5 rmmovq/mrmovq: valE = valB + valC.
- icode 8 call and icode A pushq: valE = valB - STACK_STEP.
- icode 9 ret and icode B popq: valE = valB + STACK_STEP.
- Any other icode: valE = 0.

Flags, computed on the OPq result only:
- ZF = (result == 0); SF = result[WIDTH-1].
- OF for add: A and B have the same sign and the result sign differs.
- OF for sub: A and B have different signs and the result sign differs from B.
- OF = 0 for and/xor.

CC register:
- Loads {ZF,SF,OF} at the clock edge only when icode == 6, ifun <= 3, e_stat == AOK, cc_suppress == 0 and rst == 0.
- Reset value is CC_RESET.
- M_stall does not block the CC update.

Condition x_cnd:
- Evaluated from the current registered cc, never from the flags being produced in the same cycle.
- ifun 0 always=1; 1 le=(SF^OF)|ZF; 2 l=SF^OF; 3 e=ZF; 4 ne=~ZF; 5 ge=~(SF^OF); 6 g=~(SF^OF)&~ZF.
- ifun above 6 gives 0.
- Applies to icode 2 and 7 only; all other icodes give x_cnd = 0.

Effective destination x_dstE:
- REG_NONE when icode == 2 and x_cnd == 0.
- Otherwise e_dstE.

M register update at each rising edge, first matching case wins:
- rst or M_bubble: load the bubble: stat=AOK, icode=1 (nop), cnd=0, valE=0, valA=0, dstE=dstM=REG_NONE.
- M_stall: hold all fields.
- Otherwise: load e_stat, e_icode, x_cnd, x_valE, e_valA, x_dstE, e_dstM.

Timing and boundary conditions:
- Latency is one cycle from the E inputs to the M outputs. Forwarding outputs are zero-latency.
- Reset asserted mid-operation discards the in-flight instruction on that edge; no partial state is retained.
- Invalid icode passes through with valE = 0; the stat field is carried unchanged.
- Add and subtract wrap modulo 2^WIDTH; no carry output is produced.

Test Plan:
- Reset: assert rst one cycle -> cc=100; M_icode=1, M_stat=1, M_dstE=M_dstM=F, M_valE=0.
- OPq add with WIDTH=64, valA=0x7FFFFFFFFFFFFFFF, valB=1, ifun 0 -> next cycle M_valE=0x8000000000000000, cc=011. Then subq valA=5, valB=5 -> M_valE=0, cc=100.
- cmovle (icode 2, ifun 1) with cc=000, dstE=3, valA=0x42 -> x_cnd=0, M_dstE=F, M_valE=0x42, M_cnd=0. Repeat with cc=100 -> M_dstE=3, M_cnd=1.
- cc_suppress=1 during subq producing zero, starting from cc=000 -> cc stays 000. With e_stat=ADR instead -> cc also unchanged.
- pushq valB=0x100 -> M_valE=0xF8; popq valB=0x100 -> M_valE=0x108. At WIDTH=32 pushq valB=0 -> M_valE=0xFFFFFFF8.
- Hazard control: M_stall=1 for 2 cycles while inputs change -> M outputs hold. M_stall and M_bubble both high -> bubble loaded. A jXX at the stall edge -> x_cnd is still driven combinationally.
